// File: rtl/poc_print_ctrl.sv
// poc_print_ctrl: CPU-fed byte FIFO driving the printer strobe/data/ready handshake.
// Define POC_IRQ_EN to build the interrupt-enable bit and the level interrupt output.
module poc_print_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cpu_wr,
   input  logic       i_cpu_rd,
   input  logic       i_cpu_addr,
   input  logic [7:0] i_cpu_din,
   output logic [7:0] o_cpu_dout,
   output logic       o_irq,
   output logic       o_tr,
   output logic [7:0] o_pd,
   input  logic       i_rdy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
   localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_STROBE    = 2'd1;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

   logic [1:0]    state_reg, state_next;
   logic [7:0]    tmo_cnt_reg, tmo_cnt_next;
   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [7:0]    pd_reg;
   logic [7:0]    dout_reg;
   logic          ovf_reg, tmo_reg;

   logic          empty, not_full;
   logic          push_req, push, pop;
   logic          ovf_set, tmo_set;
   logic          sr_rd;
   logic          ie_bit;
   logic [7:0]    sr_value;

   assign empty    = (count_reg == '0);
   assign not_full = (count_reg != FULL_CNT);
   assign push_req = i_cpu_wr && i_cpu_addr;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push     = push_req && (not_full || pop);
   assign ovf_set  = push_req && !not_full && !pop;
   assign sr_rd    = i_cpu_rd && !i_cpu_addr;
   assign sr_value = {not_full, empty, ovf_reg, tmo_reg, 3'b000, ie_bit};

   always_comb begin
      state_next   = state_reg;
      tmo_cnt_next = tmo_cnt_reg;
      pop          = 1'b0;
      tmo_set      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (i_rdy && !empty) begin
               pop        = 1'b1;
               state_next = ST_STROBE;
            end
         end
         ST_STROBE: begin
            tmo_cnt_next = '0;
            state_next   = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            // Ready staying high after the strobe is not completion; only a fall counts.
            if (!i_rdy) begin
               state_next = ST_WAIT_HIGH;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               tmo_set    = 1'b1;
               state_next = ST_IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 8'd1;
            end
         end
         ST_WAIT_HIGH: begin
            if (i_rdy) begin
               if (!empty) begin
                  pop        = 1'b1;
                  state_next = ST_STROBE;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg   <= ST_IDLE;
         tmo_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         tmo_cnt_reg <= tmo_cnt_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= i_cpu_din;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Print data only changes on a pop, so it stays stable through the busy period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pd_reg <= 8'h00;
      end else if (pop) begin
         pd_reg <= fifo_mem[rd_ptr_reg];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ovf_reg  <= 1'b0;
         tmo_reg  <= 1'b0;
         dout_reg <= 8'h00;
      end else begin
         // A new event wins over the clear-on-read of the same edge.
         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (sr_rd) begin
            ovf_reg <= 1'b0;
         end
         if (tmo_set) begin
            tmo_reg <= 1'b1;
         end else if (sr_rd) begin
            tmo_reg <= 1'b0;
         end
         if (i_cpu_rd) begin
            dout_reg <= i_cpu_addr ? 8'h00 : sr_value;
         end
      end
   end

`ifdef POC_IRQ_EN
   logic ie_reg;
   logic irq_reg;
   logic sr_wr;

   assign sr_wr = i_cpu_wr && !i_cpu_addr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ie_reg  <= 1'b0;
         irq_reg <= 1'b0;
      end else begin
         if (sr_wr) begin
            ie_reg <= i_cpu_din[0];
         end
         irq_reg <= ie_reg & not_full;
      end
   end

   assign ie_bit = ie_reg;
   assign o_irq  = irq_reg;
`else
   assign ie_bit = 1'b0;
   assign o_irq  = 1'b0;
`endif

   assign o_tr       = (state_reg == ST_STROBE);
   assign o_pd       = pd_reg;
   assign o_cpu_dout = dout_reg;

endmodule

// File: tb/tb_poc_print_ctrl.sv
// Scoreboard bench for poc_print_ctrl: a printer model pops expected bytes on each strobe.
// Interrupt expectations follow POC_IRQ_EN.
module tb_poc_print_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cpu_wr = 1'b0;
   logic       cpu_rd = 1'b0;
   logic       cpu_addr = 1'b0;
   logic [7:0] cpu_din = 8'h00;
   logic [7:0] cpu_dout;
   logic       irq;
   logic       tr;
   logic [7:0] pd;
   logic       rdy = 1'b1;

`ifdef POC_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] sb_q [$];
   int         rdy_mode = 0;     // 0 printer model, 1 hold busy, 2 hold ready
   int         busy_cnt = 0;
   int         cyc = 0;
   int         rise_cyc = 0;
   int         tr_count = 0;
   bit         spacing_chk = 1'b0;
   bit         burst_first = 1'b1;
   logic [7:0] held_pd = 8'h00;
   logic       ie_exp = 1'b0;

   poc_print_ctrl dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_cpu_wr   (cpu_wr),
      .i_cpu_rd   (cpu_rd),
      .i_cpu_addr (cpu_addr),
      .i_cpu_din  (cpu_din),
      .o_cpu_dout (cpu_dout),
      .o_irq      (irq),
      .o_tr       (tr),
      .o_pd       (pd),
      .i_rdy      (rdy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, got, exp);
      end else begin
         $display("[%0t] ok   %s: %0h", $time, tag, got);
      end
   endtask

   // Printer model and scoreboard consumer, all on the falling edge.
   always @(negedge clk) begin
      cyc++;
      if (tr) begin
         tr_count++;
         if (sb_q.size() == 0) begin
            check_val("strobe_unexpected", 32'(pd), 32'hFFFF_FFFF);
         end else begin
            held_pd = sb_q.pop_front();
            check_val("strobe_pd", 32'(pd), 32'(held_pd));
         end
         if (spacing_chk) begin
            if (!burst_first) begin
               check_val("strobe_spacing", 32'(cyc - rise_cyc), 32'd1);
            end
            burst_first = 1'b0;
         end
      end
      case (rdy_mode)
         0: begin
            if (busy_cnt > 0) begin
               busy_cnt--;
               if (busy_cnt == 0) begin
                  check_val("pd_held", 32'(pd), 32'(held_pd));
                  rdy = 1'b1;
                  rise_cyc = cyc;
               end
            end else if (tr) begin
               busy_cnt = $urandom_range(2, 5);
               rdy = 1'b0;
            end else begin
               rdy = 1'b1;
            end
         end
         1: rdy = 1'b0;
         default: rdy = 1'b1;
      endcase
   end

   // All CPU tasks start and end on a falling edge.
   task automatic cpu_write(input logic addr, input logic [7:0] d);
      cpu_wr = 1'b1;
      cpu_addr = addr;
      cpu_din = d;
      @(negedge clk);
      cpu_wr = 1'b0;
   endtask

   task automatic cpu_read(input logic addr, input string tag, input logic [7:0] exp);
      cpu_rd = 1'b1;
      cpu_addr = addr;
      @(negedge clk);
      cpu_rd = 1'b0;
      check_val(tag, 32'(cpu_dout), 32'(exp));
   endtask

   task automatic wait_drain(input string tag);
      bit done = 1'b0;
      for (int n = 0; n < 300 && !done; n++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && busy_cnt == 0 && !tr) done = 1'b1;
      end
      repeat (3) @(negedge clk);
      check_val({tag, "_drained"}, 32'(done), 32'd1);
   endtask

   function automatic logic [7:0] sr_exp(input logic [7:0] base);
      return base | {7'b0, ie_exp};
   endfunction

   initial begin
      int t0;
      logic [7:0] b2b [4];
      b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'h33; b2b[3] = 8'h44;

      // Reset
      repeat (3) @(negedge clk);
      check_val("rst_tr", 32'(tr), 32'd0);
      check_val("rst_pd", 32'(pd), 32'd0);
      check_val("rst_dout", 32'(cpu_dout), 32'd0);
      check_val("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      cpu_read(1'b0, "rst_sr", 8'hC0);

      // Single byte with latency of the strobe
      t0 = tr_count;
      sb_q.push_back(8'hA5);
      cpu_write(1'b1, 8'hA5);
      check_val("a5_tr_wait", 32'(tr), 32'd0);
      @(negedge clk);
      check_val("a5_tr_high", 32'(tr), 32'd1);
      @(negedge clk);
      check_val("a5_tr_low", 32'(tr), 32'd0);
      wait_drain("a5");
      check_val("a5_pulses", 32'(tr_count - t0), 32'd1);
      cpu_read(1'b0, "a5_sr", sr_exp(8'hC0));
      cpu_read(1'b1, "br_read", 8'h00);

      // Back-to-back writes
      t0 = tr_count;
      spacing_chk = 1'b1;
      burst_first = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(b2b[i]);
         cpu_write(1'b1, b2b[i]);
      end
      wait_drain("b2b");
      spacing_chk = 1'b0;
      check_val("b2b_pulses", 32'(tr_count - t0), 32'd4);

      // Overflow with the printer held busy
      rdy_mode = 1;
      repeat (2) @(negedge clk);
      t0 = tr_count;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) sb_q.push_back(8'(8'h60 + i));
         cpu_write(1'b1, 8'(8'h60 + i));
      end
      cpu_read(1'b0, "ovf_sr", sr_exp(8'h20));
      cpu_read(1'b0, "ovf_sr_clr", sr_exp(8'h00));
      check_val("ovf_no_tr", 32'(tr_count - t0), 32'd0);
      rdy_mode = 0;
      wait_drain("ovf");
      check_val("ovf_pulses", 32'(tr_count - t0), 32'd4);

      // Timeout with ready stuck high
      rdy_mode = 2;
      repeat (2) @(negedge clk);
      t0 = tr_count;
      sb_q.push_back(8'h5A);
      cpu_write(1'b1, 8'h5A);
      repeat (8) @(negedge clk);
      cpu_read(1'b0, "tmo_early", sr_exp(8'hC0));
      repeat (15) @(negedge clk);
      cpu_read(1'b0, "tmo_sr", sr_exp(8'hD0));
      cpu_read(1'b0, "tmo_sr_clr", sr_exp(8'hC0));
      check_val("tmo_pulses", 32'(tr_count - t0), 32'd1);
      check_val("tmo_sb_empty", 32'(sb_q.size()), 32'd0);

      // Interrupt enable and full-FIFO deassertion
      rdy_mode = 1;
      repeat (2) @(negedge clk);
      cpu_write(1'b0, 8'hFF);
      ie_exp = IRQ_EN;
      @(negedge clk);
      check_val("irq_on", 32'(irq), 32'(ie_exp));
      cpu_read(1'b0, "ie_sr", sr_exp(8'hC0));
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back(8'(8'h80 + i));
         cpu_write(1'b1, 8'(8'h80 + i));
      end
      check_val("irq_full_lag", 32'(irq), 32'(ie_exp));
      @(negedge clk);
      check_val("irq_full_off", 32'(irq), 32'd0);
      cpu_read(1'b0, "full_sr", sr_exp(8'h00));
      rdy_mode = 0;
      wait_drain("irq");
      check_val("irq_after_drain", 32'(irq), 32'(ie_exp));
      check_val("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[%0t] FAIL watchdog: simulation did not complete, expected finish before limit", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
